sel_mux_rr: RTL

Parametrised, registered N-input multiplexer with valid/ready handshake. It selects one of NUM request channels, either by an explicit select or by round-robin arbitration, and holds the chosen word in a one-deep output register. It is the general successor of the datapath 2:1 selector. It sits between multiple producers (ALU, memory read, immediate, forwarding paths) and a single consumer stage, such as writeback or an operand latch, that may stall.

---
 rtl/sel_mux_rr.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sel_mux_rr.sv
// sel_mux_rr: registered NUM-input multiplexer with valid/ready handshake.
// Picks one request channel per cycle, either by an explicit index (mode=0) or
// by round-robin arbitration (mode=1), and holds the word in a one-deep
// output register that a stalling consumer can drain at its own pace.
//
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_data    NUM packed words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel offer
//   in_ready   per-channel take strobe (one-hot or zero, combinational)
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index used in mode 0 (values >= NUM grant nothing)
//   out_data   registered selected word
//   out_src    index of the channel that supplied out_data
//   out_valid  out_data holds a word
//   out_ready  consumer accepts out_data this cycle
module sel_mux_rr #(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned NUM   = 2,
  localparam int unsigned SEL_W = $clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM*WIDTH-1:0] in_data,
  input  logic [NUM-1:0]       in_valid,
  output logic [NUM-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load;
  logic             fix_hit, rr_hit, grant_vld;
  logic [SEL_W-1:0] fix_idx, rr_idx, grant_idx;
  logic [WIDTH-1:0] grant_data;

  // Register can take a word when empty or being drained this cycle.
  assign load = !out_valid_q || out_ready;

  always_comb begin
    fix_hit = 1'b0;
    fix_idx = '0;
    rr_hit  = 1'b0;
    rr_idx  = '0;

    // Fixed select; sel >= NUM never matches any channel.
    for (int i = 0; i < NUM; i++) begin
      if (int'(sel) == i && in_valid[i]) begin
        fix_hit = 1'b1;
        fix_idx = SEL_W'(i);
      end
    end

    // Round-robin: first scan the channels above ptr, then wrap to 0..ptr.
    for (int i = 0; i < NUM; i++) begin
      if (!rr_hit && i > int'(ptr_q) && in_valid[i]) begin
        rr_hit = 1'b1;
        rr_idx = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM; i++) begin
      if (!rr_hit && i <= int'(ptr_q) && in_valid[i]) begin
        rr_hit = 1'b1;
        rr_idx = SEL_W'(i);
      end
    end
  end

  // reset_n gates the grant so no producer sees ready while in reset.
  assign grant_vld = reset_n && load && (mode ? rr_hit : fix_hit);
  assign grant_idx = mode ? rr_idx : fix_idx;

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < NUM; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = grant_vld;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (grant_vld) begin
      out_data_d  = grant_data;
      out_src_d   = grant_idx;
      out_valid_d = 1'b1;
      // Only round-robin grants advance the fairness pointer.
      if (mode) begin
        ptr_d = grant_idx;
      end
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_W'(NUM - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule
